pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; power of 2, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid & in_ready at clk edge.
REQ-007 SHALL have ports A, B  input  WIDTH  operands.
REQ-008 SHALL have port cntrl  input  3  op: 000 pass B, 001 LSL, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MUL.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready at clk edge.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have ports negative, zero, overflow, carry_out  output  1 each  registered flags.
REQ-013 SHALL have port busy  output  1  high while a MUL is iterating.

Function
REQ-014 SHALL implement states IDLE, MUL; output register (result, flags, out_valid) is a single entry beside the FSM.
REQ-015 in_ready SHALL equal (state==IDLE) & (!out_valid | out_ready), combinationally.
REQ-016 Ops 000-110 accepted at edge N SHALL load result/flags and set out_valid at edge N; FSM stays IDLE.
REQ-017 ADD: result = A+B mod 2^WIDTH; carry_out = bit WIDTH of the sum; overflow = signed overflow.
REQ-018 SUB: result = A+~B+1 mod 2^WIDTH; carry_out = 1 when no borrow (A>=B unsigned); overflow = signed overflow.
REQ-019 LSL: result = A << B[SHW-1:0], zero-filled; carry_out = 0; overflow = 0.
REQ-020 Pass B and AND/OR/XOR SHALL give carry_out = 0, overflow = 0.
REQ-021 For every op: negative = result[WIDTH-1]; zero = (result == 0).
REQ-022 MUL accepted at edge N SHALL latch A, B, clear a 2*WIDTH accumulator and step counter, enter MUL; busy = 1.
REQ-023 In MUL, each edge SHALL process one multiplier bit, LSB first (shift-add, unsigned); exactly WIDTH steps, no early termination.
REQ-024 At edge N+WIDTH SHALL load result = product[WIDTH-1:0], overflow = |product[2*WIDTH-1:WIDTH], carry_out = 0; set out_valid; return to IDLE; busy = 0.
REQ-025 in_ready SHALL be 0 throughout MUL; in_valid/A/B/cntrl SHALL be ignored while in MUL.
REQ-026 Edge with out_valid & out_ready and no new load SHALL clear out_valid; result/flags hold last values.
REQ-027 Simultaneous consume and accept (out_valid & out_ready & in_valid & in_ready, op != MUL) SHALL load the new result and keep out_valid = 1 (back-to-back, 1 op/cycle).
REQ-028 Simultaneous consume and MUL accept SHALL clear out_valid and enter MUL.
REQ-029 While out_valid & !out_ready, result and flags SHALL remain stable.
REQ-030 Step counter SHALL be SHW+1 bits wide so that WIDTH steps are counted without wrap.

Reset
REQ-031 reset_n low at an edge SHALL force state IDLE, out_valid 0, busy 0, result 0, negative 0, zero 0, overflow 0, carry_out 0, counter 0, accumulator 0.
REQ-032 Reset asserted mid-MUL SHALL abandon the operation; no out_valid for it after release.
REQ-033 First edge with reset_n high SHALL accept an operation if in_valid is high (in_ready = 1 out of reset).
REQ-034 Reset SHALL override any simultaneous handshake at the same edge.

Verification
REQ-035 WIDTH=64, ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> next edge result 0x8000_0000_0000_0000, negative 1, overflow 1, carry_out 0, zero 0.
REQ-036 WIDTH=64, SUB A=5, B=5 -> result 0, zero 1, carry_out 1, overflow 0; SUB A=0, B=1 -> result all-ones, carry_out 0, negative 1.
REQ-037 WIDTH=8, MUL A=0x10, B=0x11 -> in_ready 0 and busy 1 for 8 cycles, out_valid at edge N+8, result 0x10, overflow 1; MUL 3x5 -> 0x0F, overflow 0.
REQ-038 WIDTH=64, out_ready held 1, ADD/XOR/LSL on consecutive cycles -> three consecutive out_valid cycles, no bubbles, correct values (LSL A=1, B=63 -> 0x8000_0000_0000_0000).
REQ-039 out_ready held 0 after an AND result -> in_ready 0, result stable; new in_valid not accepted until out_ready rises.
REQ-040 reset_n low at MUL step 3 (WIDTH=8) -> all outputs 0, state IDLE, in_ready 1 after release, no stale out_valid.

Source files
------------

// File: rtl/pipe_alu.sv
// Single-issue ALU: one-cycle logic/arithmetic ops into a one-entry output register,
// plus an iterative shift-add unsigned multiplier that takes WIDTH cycles.
module pipe_alu #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             busy
);

  localparam logic [2:0] OP_PASS = 3'b000, OP_LSL = 3'b001, OP_ADD = 3'b010,
                         OP_SUB  = 3'b011, OP_AND = 3'b100, OP_OR  = 3'b101,
                         OP_XOR  = 3'b110, OP_MUL = 3'b111;
  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [SHW:0]       cnt_p0;
  logic [2*WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [2*WIDTH-1:0] acc_p0;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     sum_ext;
  logic               sa_neg, sb_neg;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign acc_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

  // Single-cycle datapath; SUB reuses the adder with inverted B and carry-in 1
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_ext = '0;
    sa_neg  = $signed(A) < 0;
    sb_neg  = $signed(B) < 0;
    case (cntrl)
      OP_PASS: alu_res = B;
      OP_LSL:  alu_res = A << B[SHW-1:0];
      OP_ADD: begin
        sum_ext = {1'b0, A} + {1'b0, B};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (sa_neg == sb_neg) && (alu_res[WIDTH-1] != sa_neg);
      end
      OP_SUB: begin
        sum_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (sa_neg != sb_neg) && (alu_res[WIDTH-1] != sa_neg);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
      cnt_p0    <= '0;
      acc_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (cntrl == OP_MUL) begin
              mcand_p0  <= {{WIDTH{1'b0}}, A};
              mplier_p0 <= B;
              acc_p0    <= '0;
              cnt_p0    <= '0;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              state     <= MUL;
            end else begin
              result    <= alu_res;
              negative  <= alu_res[WIDTH-1];
              zero      <= (alu_res == '0);
              overflow  <= alu_v;
              carry_out <= alu_c;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          // One multiplier bit per cycle; the final step writes the product directly
          acc_p0    <= acc_next;
          mcand_p0  <= mcand_p0 << 1;
          mplier_p0 <= mplier_p0 >> 1;
          cnt_p0    <= cnt_p0 + 1'b1;
          if (cnt_p0 == LAST_STEP) begin
            result    <= acc_next[WIDTH-1:0];
            negative  <= acc_next[WIDTH-1];
            zero      <= (acc_next[WIDTH-1:0] == '0);
            overflow  <= |acc_next[2*WIDTH-1:WIDTH];
            carry_out <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_alu.sv
// Directed bench for pipe_alu: a 64-bit instance for single-cycle ops and handshake,
// an 8-bit instance for the iterative multiplier and mid-operation reset.
module tb_pipe_alu;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        iv64, ir64, ov64, ordy64, n64, z64, v64, c64, busy64;
  logic [63:0] a64, b64, res64;
  logic [2:0]  op64;

  logic        iv8, ir8, ov8, ordy8, n8, z8, v8, c8, busy8;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;

  int tests = 0;
  int fails = 0;
  int stale = 0;

  pipe_alu #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64),
    .A(a64), .B(b64), .cntrl(op64), .out_valid(ov64), .out_ready(ordy64),
    .result(res64), .negative(n64), .zero(z64), .overflow(v64),
    .carry_out(c64), .busy(busy64)
  );

  pipe_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .cntrl(op8), .out_valid(ov8), .out_ready(ordy8),
    .result(res8), .negative(n8), .zero(z8), .overflow(v8),
    .carry_out(c8), .busy(busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    iv64 = 0; a64 = '0; b64 = '0; op64 = '0; ordy64 = 1;
    iv8  = 0; a8  = '0; b8  = '0; op8  = '0; ordy8  = 1;
    tick(); tick();
    chk("rst_ov64", ov64, 0);   chk("rst_res64", res64, 0);
    chk("rst_busy64", busy64, 0); chk("rst_z64", z64, 0);
    chk("rst_ir64", ir64, 1);   chk("rst_res8", res8, 0);
    chk("rst_ov8", ov8, 0);

    // First edge out of reset accepts: signed-overflow ADD
    reset_n = 1'b1;
    iv64 = 1; op64 = 3'b010; a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'd1;
    tick();
    chk("add_ov", ov64, 1); chk("add_res", res64, 64'h8000_0000_0000_0000);
    chk("add_n", n64, 1);   chk("add_v", v64, 1);
    chk("add_c", c64, 0);   chk("add_z", z64, 0);

    op64 = 3'b011; a64 = 64'd5; b64 = 64'd5;
    tick();
    chk("sub55_res", res64, 0); chk("sub55_z", z64, 1);
    chk("sub55_c", c64, 1);     chk("sub55_v", v64, 0);

    a64 = 64'd0; b64 = 64'd1;
    tick();
    chk("sub01_res", res64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub01_c", c64, 0); chk("sub01_n", n64, 1);

    // Back-to-back ADD, XOR, LSL with out_ready held high
    op64 = 3'b010; a64 = 64'd3; b64 = 64'd4;
    tick();
    chk("b2b_add_ov", ov64, 1); chk("b2b_add_res", res64, 64'd7);
    op64 = 3'b110; a64 = 64'hF0; b64 = 64'hFF;
    tick();
    chk("b2b_xor_ov", ov64, 1); chk("b2b_xor_res", res64, 64'h0F);
    op64 = 3'b001; a64 = 64'd1; b64 = 64'd63;
    tick();
    chk("b2b_lsl_ov", ov64, 1); chk("b2b_lsl_res", res64, 64'h8000_0000_0000_0000);
    chk("b2b_lsl_c", c64, 0);   chk("b2b_lsl_v", v64, 0);
    iv64 = 0;
    tick();
    chk("drain_ov", ov64, 0); chk("drain_hold", res64, 64'h8000_0000_0000_0000);

    // Backpressure: AND result held while out_ready low
    iv64 = 1; op64 = 3'b100; a64 = 64'hFF00; b64 = 64'h0FF0; ordy64 = 0;
    tick();
    chk("and_ov", ov64, 1); chk("and_res", res64, 64'h0F00); chk("bp_ir", ir64, 0);
    op64 = 3'b101; a64 = 64'd1; b64 = 64'd2;
    tick();
    chk("bp_hold_res", res64, 64'h0F00); chk("bp_hold_ov", ov64, 1); chk("bp_ir2", ir64, 0);
    ordy64 = 1;
    #1;
    chk("bp_ir_rise", ir64, 1);
    tick();
    chk("or_res", res64, 64'd3); chk("or_ov", ov64, 1);
    iv64 = 0;
    tick();
    chk("or_drain", ov64, 0);

    // 8-bit MUL 0x10 * 0x11 = 0x110; other inputs ignored while iterating
    iv8 = 1; op8 = 3'b111; a8 = 8'h10; b8 = 8'h11;
    tick();
    chk("mul1_busy", busy8, 1); chk("mul1_ir", ir8, 0); chk("mul1_ov", ov8, 0);
    op8 = 3'b010; a8 = 8'd1; b8 = 8'd1;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("mul1_busy_k", busy8, 1); chk("mul1_ir_k", ir8, 0); chk("mul1_ov_k", ov8, 0);
    end
    tick();
    chk("mul1_done_ov", ov8, 1); chk("mul1_res", res8, 8'h10);
    chk("mul1_v", v8, 1); chk("mul1_c", c8, 0); chk("mul1_busy_end", busy8, 0);

    // MUL 3*5 accepted while the previous product is consumed
    op8 = 3'b111; a8 = 8'd3; b8 = 8'd5;
    tick();
    chk("mul2_ov_clr", ov8, 0); chk("mul2_busy", busy8, 1);
    iv8 = 0;
    for (int k = 1; k < 8; k++) tick();
    chk("mul2_ov_early", ov8, 0);
    tick();
    chk("mul2_ov", ov8, 1); chk("mul2_res", res8, 8'h0F);
    chk("mul2_v", v8, 0); chk("mul2_z", z8, 0); chk("mul2_n", n8, 0);

    // Reset at MUL step 3 abandons the product
    iv8 = 1; op8 = 3'b111; a8 = 8'd3; b8 = 8'd5;
    tick();
    iv8 = 0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    chk("mrst_busy", busy8, 0); chk("mrst_ov", ov8, 0); chk("mrst_res", res8, 0);
    chk("mrst_v", v8, 0);       chk("mrst_z", z8, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ov8 !== 1'b0 || busy8 !== 1'b0) stale++;
    end
    chk("mrst_no_stale", 64'(stale), 0);
    chk("mrst_ir", ir8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
